// File: rtl/valid_ack_pkg.sv
// valid_ack_pkg: shared types and constants for the valid/ack transmit controller.
package valid_ack_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_LOW = 2'd2
    } state_t;
    localparam bit MODE_FOUR_PHASE = 1'b1;
    localparam bit MODE_TWO_PHASE  = 1'b0;
    localparam int SENT_W          = 16;
endpackage

// File: rtl/valid_ack_tx_ctrl_sync_fifo.sv
// sync_fifo: power-of-two circular buffer with occupancy count; head is shown combinationally.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];
    // Storage is cleared on reset so the link data reads zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= wdata;
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/valid_ack_tx_ctrl.sv
// valid_ack_tx_ctrl: FIFO-buffered sender for a four-phase or two-phase valid/ack link,
// with ack-timeout flag and completed-transfer counter.
module valid_ack_tx_ctrl
    import valid_ack_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter bit FOUR_PHASE = 1'b1,
    parameter int TIMEOUT    = 16
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   tx_valid,
    output logic [DATA_W-1:0]      tx_data,
    input  logic                   tx_ack,
    output logic [$clog2(DEPTH):0] level,
    output logic                   timeout_err,
    input  logic                   err_clr,
    output logic [SENT_W-1:0]      sent_cnt
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam bit FP = (FOUR_PHASE == MODE_FOUR_PHASE);
    state_t            state, state_nxt;
    logic              full, empty, push, done, more;
    logic              tx_valid_nxt, tmo_set, err_nxt;
    logic [TW-1:0]     tmo_cnt, tmo_nxt;
    logic [SENT_W-1:0] sent_nxt;
    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign done     = (state == REQ) & (FP ? tx_ack : (tx_ack == tx_valid));
    // Another word remains after this pop, counting one arriving on the same edge.
    assign more     = (level > LW'(1)) | push;
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (done),
        .wdata (in_data),
        .rdata (tx_data),
        .level (level),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx_valid    <= 1'b0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
            sent_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            tx_valid    <= tx_valid_nxt;
            tmo_cnt     <= tmo_nxt;
            timeout_err <= err_nxt;
            sent_cnt    <= sent_nxt;
        end
    end
    always_comb begin
        state_nxt = (state == IDLE) ? (empty ? IDLE : REQ)
                  : (state == REQ)  ? (!done ? REQ : FP ? ACK_LOW : more ? REQ : IDLE)
                  : (tx_ack ? ACK_LOW : IDLE);
    end
    always_comb begin
        tx_valid_nxt = tx_valid;
        if (state == IDLE && !empty) tx_valid_nxt = FP ? 1'b1 : ~tx_valid;
        if (done) tx_valid_nxt = FP ? 1'b0 : (more ? ~tx_valid : tx_valid);
        // Counter restarts for each request and saturates so the flag fires once.
        tmo_nxt  = (state != REQ || done) ? '0
                 : (tmo_cnt == TW'(TIMEOUT)) ? tmo_cnt : tmo_cnt + TW'(1);
        tmo_set  = (TIMEOUT != 0) && (state == REQ) && !done && (tmo_cnt == TW'(TIMEOUT - 1));
        err_nxt  = tmo_set | (timeout_err & ~err_clr);
        sent_nxt = sent_cnt + SENT_W'(done);
    end
endmodule

// File: tb/tb_valid_ack_tx_ctrl.sv
// tb_valid_ack_tx_ctrl: runs a four-phase and a two-phase controller side by side against a
// queue-based reference; the monitor pops expected words whenever a new link request appears.
module tb_valid_ack_tx_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int vectors     = 0;
    int miscompares = 0;
    bit done_f [2];

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s lane%0d: got %0h expected %0h at %0t", nm, g, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam bit FP = (g == 0);
        logic rst = 1'b1, in_valid = 1'b0, err_clr = 1'b0, tx_ack = 1'b0, hold = 1'b0;
        logic [DW-1:0] in_data = '0;
        logic in_ready, tx_valid, timeout_err;
        logic [DW-1:0] tx_data;
        logic [$clog2(DEPTH):0] level;
        logic [15:0] sent_cnt;
        logic [DW-1:0] exp_q [$];
        int pushes = 0;
        int pops   = 0;

        valid_ack_tx_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .FOUR_PHASE(FP), .TIMEOUT(TMO)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
            .tx_valid(tx_valid), .tx_data(tx_data), .tx_ack(tx_ack), .level(level),
            .timeout_err(timeout_err), .err_clr(err_clr), .sent_cnt(sent_cnt)
        );

        // Receiver: ack follows the request after a random delay; works for both protocols.
        initial begin : rx
            int dly = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    tx_ack = 1'b0;
                    dly    = 0;
                end else if (!hold && tx_ack != tx_valid) begin
                    if (dly == 0) begin
                        tx_ack = tx_valid;
                        dly    = $urandom_range(0, 3);
                    end else dly--;
                end
            end
        end

        initial begin : mon
            bit pend = 0, prev_tv = 0, exp_err = 0, comp, set_now;
            int age = 0;
            logic [DW-1:0] cur = '0;
            forever begin
                @(posedge clk);
                #1;
                if (rst) begin
                    pend = 0; exp_err = 0; age = 0; pops = 0;
                    chk("rst_tx_valid", g, tx_valid, 0);
                    chk("rst_level", g, level, 0);
                    chk("rst_in_ready", g, in_ready, 1);
                    chk("rst_sent_cnt", g, sent_cnt, 0);
                    chk("rst_timeout_err", g, timeout_err, 0);
                    chk("rst_tx_data", g, tx_data, 0);
                end else begin
                    comp    = pend && (tx_ack == prev_tv);
                    set_now = 0;
                    if (pend && !comp) begin
                        age++;
                        set_now = (age == TMO);
                    end
                    exp_err = set_now ? 1'b1 : (err_clr ? 1'b0 : exp_err);
                    if (comp) begin
                        pops++;
                        pend = 0;
                    end
                    if (tx_valid != prev_tv && (!FP || tx_valid)) begin
                        vectors++;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL spurious_req lane%0d: got request data %0h expected no request at %0t", g, tx_data, $time);
                        end else begin
                            cur = exp_q.pop_front();
                            if (tx_data !== cur) begin
                                miscompares++;
                                $display("FAIL tx_data lane%0d: got %0h expected %0h at %0t", g, tx_data, cur, $time);
                            end
                        end
                        pend = 1;
                        age  = 0;
                    end else if (pend) chk("tx_data_stable", g, tx_data, cur);
                    chk("level", g, level, pushes - pops);
                    chk("in_ready", g, in_ready, (pushes - pops) < DEPTH);
                    chk("sent_cnt", g, sent_cnt, pops & 16'hFFFF);
                    chk("timeout_err", g, timeout_err, exp_err);
                end
                prev_tv = rst ? 1'b0 : tx_valid;
            end
        end

        task automatic send(input logic [DW-1:0] d);
            int t = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = d;
                t++;
            end while (!in_ready && t < 500);
            vectors++;
            if (in_ready) begin
                exp_q.push_back(d);
                pushes++;
            end else begin
                miscompares++;
                $display("FAIL push_stall lane%0d: in_ready %0b expected 1 within 500 cycles", g, in_ready);
            end
        endtask

        task automatic idle(input int n);
            repeat (n) begin
                @(negedge clk);
                in_valid = 1'b0;
                err_clr  = 1'b0;
            end
        endtask

        task automatic wait_pops(input int n);
            int t = 0;
            idle(1);
            while (pops < n && t < 2000) begin
                idle(1);
                t++;
            end
            vectors++;
            if (pops < n) begin
                miscompares++;
                $display("FAIL drain lane%0d: completions %0d expected %0d", g, pops, n);
            end
        endtask

        initial begin : drv
            idle(2);
            rst = 1'b0;
            // Ack withheld: four words fill the FIFO, the fifth is held by the source.
            hold = 1'b1;
            send(8'hA1); send(8'hB2); send(8'hD8); send(8'hFF);
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hC9;
            chk("full_level", g, level, 4);
            chk("full_in_ready", g, in_ready, 0);
            repeat (3) @(negedge clk);
            chk("held_level", g, level, 4);
            hold = 1'b0;
            send(8'hC9);
            wait_pops(5);
            chk("sent_after_five", g, sent_cnt, 5);
            idle(4);
            // Timeout: ack withheld for ~20 cycles, transfer still completes, flag sticks until cleared.
            hold = 1'b1;
            send(8'h3C);
            idle(22);
            chk("timeout_raised", g, timeout_err, 1);
            hold = 1'b0;
            wait_pops(6);
            idle(3);
            chk("timeout_sticky", g, timeout_err, 1);
            @(negedge clk);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            chk("timeout_cleared", g, timeout_err, 0);
            // Random traffic with periodic ack stalls to exercise full-FIFO push/pop overlap.
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                hold     = (i % 50) < 8;
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = DW'($urandom);
                if (in_valid && in_ready) begin
                    exp_q.push_back(in_data);
                    pushes++;
                end
            end
            hold = 1'b0;
            wait_pops(pushes);
            idle(4);
            // Reset while a request is outstanding with three words queued.
            hold = 1'b1;
            send(8'h11); send(8'h22); send(8'h33);
            idle(4);
            chk("pre_rst_level", g, level, 3);
            rst = 1'b1;
            pushes = 0;
            exp_q.delete();
            #1;
            chk("async_tx_valid", g, tx_valid, 0);
            chk("async_level", g, level, 0);
            chk("async_in_ready", g, in_ready, 1);
            chk("async_sent_cnt", g, sent_cnt, 0);
            chk("async_timeout_err", g, timeout_err, 0);
            idle(2);
            rst  = 1'b0;
            hold = 1'b0;
            send(8'h5A);
            wait_pops(1);
            chk("post_rst_sent", g, sent_cnt, 1);
            idle(5);
            done_f[g] = 1'b1;
        end
    end

    initial begin : fin
        int t = 0;
        while (!(done_f[0] && done_f[1]) && t < 50000) begin
            @(posedge clk);
            t++;
        end
        if (!(done_f[0] && done_f[1])) begin
            miscompares++;
            $display("FAIL watchdog: lanes finished %0d/%0d expected 1/1", done_f[0], done_f[1]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
